// File: rtl/mul_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mul_pkg
//  Description : Shared definitions for the multiplier issue path: datapath
//                width, watchdog defaults, FSM state encoding and the
//                word-operation sign-extension helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package mul_pkg;

    localparam int MUL_XLEN           = 64;
    localparam int MUL_TIMEOUT_CYCLES = 80;
    localparam int MUL_CNT_W          = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_DONE = 2'd2,
        RESP      = 2'd3
    } mul_state_t;

    // Sign-extend a 32-bit word result/operand to the full datapath width.
    function automatic logic [MUL_XLEN-1:0] sext_word(input logic [31:0] val);
        return {{(MUL_XLEN-32){val[31]}}, val};
    endfunction

endpackage
`default_nettype wire

// File: rtl/mul_operand_prep.sv
`default_nettype none
// ============================================================================
//  Module      : mul_operand_prep
//  Description : Combinational operand preparation for a multi-cycle
//                arithmetic unit. Word operations sign-extend the low 32 bits
//                of each operand; full-width operations pass through. Flags
//                when either prepared operand is zero.
//  Ports       : i_word      - 1 = word (32-bit) operation
//                i_rs1/i_rs2 - raw operands
//                o_rs1_prep/o_rs2_prep - prepared operands
//                o_zero      - either prepared operand equals zero
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_operand_prep
    import mul_pkg::*;
#(
    parameter int XLEN = MUL_XLEN
) (
    input  logic            i_word,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    output logic [XLEN-1:0] o_rs1_prep,
    output logic [XLEN-1:0] o_rs2_prep,
    output logic            o_zero
);

    logic [XLEN-1:0] w_rs1_prep;
    logic [XLEN-1:0] w_rs2_prep;

    assign w_rs1_prep = i_word ? sext_word(i_rs1[31:0]) : i_rs1;
    assign w_rs2_prep = i_word ? sext_word(i_rs2[31:0]) : i_rs2;

    // Zero detection must look at the prepared values: a word operation whose
    // low half is zero is a zero operand regardless of the upper bits.
    assign o_zero     = (w_rs1_prep == '0) || (w_rs2_prep == '0);
    assign o_rs1_prep = w_rs1_prep;
    assign o_rs2_prep = w_rs2_prep;

endmodule
`default_nettype wire

// File: rtl/mul_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mul_issue_ctrl
//  Description : Issue/handshake controller in front of a multi-cycle
//                multiplier. Accepts requests over valid/ready, prepares
//                operands (word sign-extension, zero bypass), pulses start,
//                waits for done with a watchdog, and buffers one response for
//                writeback over valid/ready. Flush kills any in-flight op.
//  Ports       : clk, reset_i (async, active low)
//                req_*   - request channel from execute
//                flush_i - pipeline flush
//                mul_*   - multiplier interface (start pulse, operands,
//                          done level, product)
//                resp_*  - one-entry response channel to writeback
//                busy_o, timeout_o - status
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_issue_ctrl
    import mul_pkg::*;
#(
    parameter int XLEN           = MUL_XLEN,
    parameter int TIMEOUT_CYCLES = MUL_TIMEOUT_CYCLES,
    parameter int CNT_W          = MUL_CNT_W
) (
    input  logic            clk,
    input  logic            reset_i,

    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic            req_word_i,
    input  logic [XLEN-1:0] req_rs1_i,
    input  logic [XLEN-1:0] req_rs2_i,
    input  logic [4:0]      req_rd_i,

    input  logic            flush_i,

    output logic            mul_start_o,
    output logic [XLEN-1:0] mul_multiplier_o,
    output logic [XLEN-1:0] mul_multiplicand_o,
    input  logic            mul_done_i,
    input  logic [XLEN-1:0] mul_product_i,

    output logic            resp_valid_o,
    input  logic            resp_ready_i,
    output logic [4:0]      resp_rd_o,
    output logic [XLEN-1:0] resp_data_o,
    output logic            resp_err_o,

    output logic            busy_o,
    output logic            timeout_o
);

    mul_state_t      r_state;
    logic [XLEN-1:0] r_op_a;
    logic [XLEN-1:0] r_op_b;
    logic [XLEN-1:0] r_res_data;
    logic [4:0]      r_rd;
    logic            r_word;
    logic            r_res_err;
    logic [CNT_W-1:0] r_cnt;

    logic [XLEN-1:0] w_rs1_prep;
    logic [XLEN-1:0] w_rs2_prep;
    logic            w_prep_zero;
    logic            w_accept;
    logic            w_sample_done;
    logic            w_expire;
    logic [XLEN-1:0] w_result;

    mul_operand_prep #(
        .XLEN (XLEN)
    ) u_prep (
        .i_word     (req_word_i),
        .i_rs1      (req_rs1_i),
        .i_rs2      (req_rs2_i),
        .o_rs1_prep (w_rs1_prep),
        .o_rs2_prep (w_rs2_prep),
        .o_zero     (w_prep_zero)
    );

    // A flush in IDLE still shows ready but the handshake is discarded.
    assign w_accept = (r_state == IDLE) && req_valid_i && !flush_i;

    // r_cnt counts completed WAIT_DONE cycles, so r_cnt == 0 identifies the
    // first WAIT_DONE cycle, where a done level left over from the previous
    // operation must not be taken as completion.
    assign w_sample_done = (r_state == WAIT_DONE) && (r_cnt != '0) && mul_done_i;

    // The current WAIT_DONE cycle is number r_cnt+1; expiry happens on the
    // TIMEOUT_CYCLES-th one unless done is seen in that same cycle.
    assign w_expire = (r_state == WAIT_DONE) && !w_sample_done &&
                      (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    assign w_result = r_word ? sext_word(mul_product_i[31:0]) : mul_product_i;

    always_ff @(posedge clk or negedge reset_i) begin
        if (!reset_i) begin
            r_state    <= IDLE;
            r_op_a     <= '0;
            r_op_b     <= '0;
            r_res_data <= '0;
            r_rd       <= '0;
            r_word     <= 1'b0;
            r_res_err  <= 1'b0;
            r_cnt      <= '0;
        end else if (flush_i) begin
            // Any pending response or in-flight operation is dropped.
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_op_a <= w_rs1_prep;
                        r_op_b <= w_rs2_prep;
                        r_rd   <= req_rd_i;
                        r_word <= req_word_i;
                        if (req_rd_i == 5'd0) begin
                            // Result would be discarded: consume the request silently.
                            r_state <= IDLE;
                        end else if (w_prep_zero) begin
                            r_res_data <= '0;
                            r_res_err  <= 1'b0;
                            r_state    <= RESP;
                        end else begin
                            r_state <= START;
                        end
                    end
                end
                START: begin
                    r_cnt   <= '0;
                    r_state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (w_sample_done) begin
                        r_res_data <= w_result;
                        r_res_err  <= 1'b0;
                        r_cnt      <= '0;
                        r_state    <= RESP;
                    end else if (w_expire) begin
                        r_res_data <= '0;
                        r_res_err  <= 1'b1;
                        r_cnt      <= '0;
                        r_state    <= RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (resp_ready_i) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign req_ready_o        = (r_state == IDLE);
    // A flush arriving in START suppresses the pulse so nothing is issued.
    assign mul_start_o        = (r_state == START) && !flush_i;
    assign mul_multiplier_o   = r_op_a;
    assign mul_multiplicand_o = r_op_b;
    assign resp_valid_o       = (r_state == RESP);
    assign resp_rd_o          = r_rd;
    assign resp_data_o        = r_res_data;
    assign resp_err_o         = r_res_err;
    assign busy_o             = (r_state != IDLE);
    assign timeout_o          = w_expire && !flush_i;

endmodule
`default_nettype wire
